// File: rtl/fifo_egress_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_egress_skid_pkg
//  Description : Shared types and constants for the FIFO egress skid stage.
//                Holds the skid-buffer occupancy encoding and the default
//                width of the delivered-beat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_egress_skid_pkg;

    // Skid buffer occupancy: 0, 1 or 2 buffered beats. The encoding matches
    // the numeric occupancy, so the value 2'b11 is unreachable.
    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_state_t;

    // Default width of the delivered-beat counter.
    localparam int unsigned DEF_CNT_W = 16;

endpackage : fifo_egress_skid_pkg
`default_nettype wire

// File: rtl/fifo_egress_skid_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that saturates at all-ones (no wrap).
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset, clears count
//                inc_i    - count one event this cycle
//                cnt_o    - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // Saturation value is the all-ones pattern at the counter width.
    localparam logic [W-1:0] SAT = '1;
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fifo_egress_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_egress_skid
//  Description : Drains a fall-through FIFO pop interface into a registered
//                valid/ready stream through a 2-entry skid buffer. The pop
//                strobe never depends on downstream ready, so there is no
//                combinational path from out_ready_i to the FIFO. Keeps a
//                saturating count of delivered beats.
//  Ports       : clk, reset_n        - clock / async active-low reset
//                enable_i            - allow new pops (draining unaffected)
//                fifo_empty_i        - FIFO empty flag
//                fifo_pop_data_i     - FIFO head data (fall-through)
//                fifo_pop_o          - pop strobe to the FIFO
//                out_valid_o/ready_i - output handshake
//                out_data_o          - output beat data
//                beat_cnt_o          - delivered beats, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_egress_skid
    import fifo_egress_skid_pkg::*;
#(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              fifo_pop_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  beat_cnt_o
);

    occ_state_t        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic w_pop;
    logic w_xfer;

    // Pop is decided from registered occupancy only. The reset_n term keeps
    // the strobe low for the whole time reset is held.
    assign w_pop       = reset_n & enable_i & ~fifo_empty_i & (occ_q != OCC_2);
    assign out_valid_o = (occ_q != OCC_0);
    assign w_xfer      = out_valid_o & out_ready_i;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        unique case (occ_q)
            OCC_0: begin
                if (w_pop) begin
                    head_d = fifo_pop_data_i;
                    occ_d  = OCC_1;
                end
            end
            OCC_1: begin
                if (w_pop && !w_xfer) begin
                    // Head is still waiting; the new beat queues behind it.
                    skid_d = fifo_pop_data_i;
                    occ_d  = OCC_2;
                end else if (w_pop && w_xfer) begin
                    // Steady-state streaming: replace the departing head.
                    head_d = fifo_pop_data_i;
                end else if (w_xfer) begin
                    occ_d  = OCC_0;
                end
            end
            OCC_2: begin
                // Full: no pop possible, only the skid entry advances.
                if (w_xfer) begin
                    head_d = skid_q;
                    occ_d  = OCC_1;
                end
            end
            default: begin
                occ_d = OCC_0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= OCC_0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign fifo_pop_o = w_pop;
    assign out_data_o = head_q;

    sat_counter #(
        .W (CNT_W)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_xfer),
        .cnt_o   (beat_cnt_o)
    );

endmodule : fifo_egress_skid
`default_nettype wire
